// File: rtl/nexys_input_cond.sv
`default_nettype none
// ============================================================================
// Module   : nexys_input_cond
// Purpose  : Synchronizes and debounces the pushbutton and slide switches,
//            and produces the button-IRQ and switch-change pulses.
// Revision : 1.0 - initial release
// ============================================================================
module nexys_input_cond #(
  parameter int NUM_SW          = 16,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              btn_i,
  input  logic [NUM_SW-1:0] sw_i,
  output logic              btn_o,
  output logic [NUM_SW-1:0] sw_o,
  output logic              irq_btn_o,
  output logic              sw_chg_o
);

  localparam int c_num_ch = NUM_SW + 1;
  localparam int c_cnt_w  = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  generate
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("nexys_input_cond: DEBOUNCE_CYCLES must be at least 1");
    end
  endgenerate

  // Channel 0 is the button, channels 1..NUM_SW are the switches.
  logic [c_num_ch-1:0] w_raw;
  logic [c_num_ch-1:0] w_stable;
  logic [c_num_ch-1:0] w_accept;
  logic                w_btn_rise;
  logic                r_irq_btn;
  logic                r_sw_chg;

  assign w_raw = {sw_i, btn_i};

  generate
    for (genvar i = 0; i < c_num_ch; i++) begin : g_chan
      logic               r_s1;
      logic               r_s2;
      logic               r_stable;
      logic [c_cnt_w-1:0] r_cnt;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_s1     <= 1'b0;
          r_s2     <= 1'b0;
          r_stable <= 1'b0;
          r_cnt    <= '0;
        end else begin
          r_s1 <= w_raw[i];
          r_s2 <= r_s1;
          // Any agreement restarts the count, so only an unbroken run is accepted.
          if (r_s2 == r_stable) begin
            r_cnt <= '0;
          end else if (r_cnt == c_cnt_last) begin
            r_stable <= r_s2;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
      end

      assign w_accept[i] = (r_s2 != r_stable) && (r_cnt == c_cnt_last);
      assign w_stable[i] = r_stable;
    end
  endgenerate

  // Pulses are registered alongside the stable flops so they line up with the new level.
  assign w_btn_rise = w_accept[0] & ~w_stable[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_irq_btn <= 1'b0;
      r_sw_chg  <= 1'b0;
    end else begin
      r_irq_btn <= w_btn_rise;
      r_sw_chg  <= |w_accept[c_num_ch-1:1];
    end
  end

  assign btn_o     = w_stable[0];
  assign sw_o      = w_stable[c_num_ch-1:1];
  assign irq_btn_o = r_irq_btn;
  assign sw_chg_o  = r_sw_chg;

endmodule
`default_nettype wire

// File: tb/tb_nexys_input_cond.sv
`default_nettype none
// ============================================================================
// Module   : tb_nexys_input_cond
// Purpose  : Directed and randomized checks of nexys_input_cond (D=4, 16 SW).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nexys_input_cond;

  localparam int NSW = 16;
  localparam int D   = 4;
  localparam int MAXE = 4096;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            btn_i;
  logic [NSW-1:0]  sw_i;
  logic            btn_o;
  logic [NSW-1:0]  sw_o;
  logic            irq_btn_o;
  logic            sw_chg_o;

  always #5 clk = ~clk;

  nexys_input_cond #(.NUM_SW(NSW), .DEBOUNCE_CYCLES(D)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .btn_i    (btn_i),
    .sw_i     (sw_i),
    .btn_o    (btn_o),
    .sw_o     (sw_o),
    .irq_btn_o(irq_btn_o),
    .sw_chg_o (sw_chg_o)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: histories of raw samples and reset, indexed by edge number.
  logic [NSW:0] raw_hist [MAXE];
  logic [NSW:0] cmp_hist [MAXE];
  bit           rst_hist [MAXE];
  int           last_ev  [NSW+1];
  int           n = -1;
  logic [NSW:0] m_stable = '0;
  logic         m_irq = 1'b0;
  logic         m_chg = 1'b0;
  int           irq_seen = 0;
  int           chg_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge: update the model from the inputs seen at the edge, then compare.
  task automatic step();
    bit all_diff;
    @(posedge clk);
    n++;
    raw_hist[n] = {sw_i, btn_i};
    rst_hist[n] = rst_i;
    // Value the debouncer compares at this edge: the raw level from two edges ago.
    if (n < 2)                               cmp_hist[n] = '0;
    else if (rst_hist[n-1] || rst_hist[n-2]) cmp_hist[n] = '0;
    else                                     cmp_hist[n] = raw_hist[n-2];
    m_irq = 1'b0;
    m_chg = 1'b0;
    if (rst_i) begin
      m_stable = '0;
      for (int c = 0; c <= NSW; c++) last_ev[c] = n;
    end else begin
      for (int c = 0; c <= NSW; c++) begin
        if (n - last_ev[c] >= D) begin
          all_diff = 1'b1;
          for (int j = 0; j < D; j++)
            if (cmp_hist[n-j][c] == m_stable[c]) all_diff = 1'b0;
          if (all_diff) begin
            m_stable[c] = ~m_stable[c];
            last_ev[c]  = n;
            if (c == 0) m_irq = m_stable[0];
            else        m_chg = 1'b1;
          end
        end
      end
    end
    #1;
    check("btn_o", 32'(btn_o), 32'(m_stable[0]));
    check("sw_o", 32'(sw_o), 32'(m_stable[NSW:1]));
    check("irq_btn_o", 32'(irq_btn_o), 32'(m_irq));
    check("sw_chg_o", 32'(sw_chg_o), 32'(m_chg));
    irq_seen += int'(irq_btn_o);
    chg_seen += int'(sw_chg_o);
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  initial begin
    rst_i = 1'b1;
    btn_i = 1'b1;
    sw_i  = 16'hFFFF;

    // Reset with inputs high, then release.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_outs", {btn_o, irq_btn_o, sw_chg_o, sw_o}, 32'h0);
    end
    rst_i = 1'b0;
    irq_seen = 0; chg_seen = 0;
    steps(5);
    check("rst_rel_early_btn", 32'(btn_o), 32'h0);
    step();
    check("rst_rel_btn", 32'(btn_o), 32'h1);
    check("rst_rel_sw", 32'(sw_o), 32'hFFFF);
    check("rst_rel_irq", 32'(irq_btn_o), 32'h1);
    check("rst_rel_chg", 32'(sw_chg_o), 32'h1);
    steps(2);
    check("rst_rel_pulse_cnt", 32'(irq_seen + chg_seen), 32'd2);

    // Falling edge of the button never raises the IRQ.
    btn_i = 1'b0; irq_seen = 0;
    steps(5);
    check("fall_early_btn", 32'(btn_o), 32'h1);
    step();
    check("fall_btn", 32'(btn_o), 32'h0);
    steps(2);
    check("fall_irq_cnt", 32'(irq_seen), 32'd0);

    // Bounce: alternate for 10 cycles, then hold high.
    irq_seen = 0;
    for (int i = 0; i < 10; i++) begin
      btn_i = (i % 2 == 0);
      step();
    end
    check("bounce_irq_during", 32'(irq_seen), 32'd0);
    btn_i = 1'b1;
    steps(5);
    check("bounce_irq_early", 32'(irq_seen), 32'd0);
    step();
    check("bounce_irq_at5", 32'(irq_btn_o), 32'h1);
    steps(3);
    check("bounce_irq_cnt", 32'(irq_seen), 32'd1);
    btn_i = 1'b0;
    steps(8);

    // Glitch shorter than the debounce window.
    irq_seen = 0;
    btn_i = 1'b1;
    steps(3);
    btn_i = 1'b0;
    steps(8);
    check("glitch_irq_cnt", 32'(irq_seen), 32'd0);
    check("glitch_btn", 32'(btn_o), 32'h0);

    // Switch bus: clear, then 0 -> A5A5 -> 0.
    sw_i = 16'h0000;
    steps(8);
    chg_seen = 0;
    sw_i = 16'hA5A5;
    steps(5);
    check("sw_early", 32'(sw_o), 32'h0);
    step();
    check("sw_a5a5", 32'(sw_o), 32'hA5A5);
    check("sw_chg_a5a5", 32'(sw_chg_o), 32'h1);
    sw_i = 16'h0000;
    steps(6);
    check("sw_back0", 32'(sw_o), 32'h0);
    steps(2);
    check("sw_chg_cnt", 32'(chg_seen), 32'd2);

    // Reset pulse while the button count is at 2.
    irq_seen = 0;
    btn_i = 1'b1;
    steps(4);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    steps(5);
    check("midrst_early_btn", 32'(btn_o), 32'h0);
    step();
    check("midrst_btn", 32'(btn_o), 32'h1);
    steps(2);
    check("midrst_irq_cnt", 32'(irq_seen), 32'd1);
    btn_i = 1'b0;
    steps(8);

    // Button and switch accepted on the same edge.
    btn_i = 1'b1;
    sw_i  = 16'h1234;
    steps(6);
    check("simul_irq", 32'(irq_btn_o), 32'h1);
    check("simul_chg", 32'(sw_chg_o), 32'h1);

    // Randomized bouncing inputs with occasional reset.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(2, 0) == 0) btn_i = ~btn_i;
      if ($urandom_range(3, 0) == 0) sw_i = sw_i ^ 16'(1 << $urandom_range(15, 0));
      if ($urandom_range(7, 0) == 0) sw_i = 16'($urandom);
      rst_i = ($urandom_range(99, 0) == 0);
      step();
      // Long quiet stretches let accepted levels appear.
      if ($urandom_range(9, 0) == 0) begin
        rst_i = 1'b0;
        steps(7);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nexys_input_cond.md
NEXYS_INPUT_COND -- requirements
Module: nexys_input_cond

Interface
REQ-001 SHALL have parameter NUM_SW, default 16, number of slide-switch channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES (D), default 500000, consecutive clk_i cycles of disagreement required to accept a new level; D < 1 SHALL be an elaboration error.
REQ-003 SHALL have port clk_i, input, 1, sole clock (PLL output).
REQ-004 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-005 SHALL have port btn_i, input, 1, raw asynchronous pushbutton.
REQ-006 SHALL have port sw_i, input, NUM_SW, raw asynchronous slide switches.
REQ-007 SHALL have port btn_o, output, 1, debounced button level.
REQ-008 SHALL have port sw_o, output, NUM_SW, debounced switch levels, feeding the SoC GPIO input.
REQ-009 SHALL have port irq_btn_o, output, 1, one-cycle pulse on each debounced button rising edge, feeding the SoC button IRQ.
REQ-010 SHALL have port sw_chg_o, output, 1, one-cycle pulse when any debounced switch level changes.

Function
REQ-011 Each of the NUM_SW+1 channels SHALL pass its raw input through a two-flop synchronizer (s1, s2) before any other logic.
REQ-012 Each channel SHALL hold a stable register (drives its output directly) and a counter of width clog2(D+1), minimum 1 bit.
REQ-013 At each edge: if s2 == stable, counter <= 0.
REQ-014 At each edge: if s2 != stable and counter < D-1, counter <= counter+1, stable unchanged.
REQ-015 At each edge: if s2 != stable and counter == D-1, stable <= s2 and counter <= 0.
REQ-016 Any return of s2 to the stable value before acceptance SHALL restart the count from 0 (bounce rejection).
REQ-017 Latency: an input held at a new level from sampling edge 0 SHALL appear on its output after edge D+1, with no earlier change.
REQ-018 An input disagreement lasting fewer than D consecutive s2 cycles SHALL produce no output change.
REQ-019 irq_btn_o SHALL be registered and high exactly in the first cycle btn_o is 1 after being 0; it SHALL never assert on a falling edge.
REQ-020 sw_chg_o SHALL be registered and high exactly in the first cycle any sw_o bit differs from its previous value.
REQ-021 Multiple switches changing at the same edge SHALL produce a single one-cycle sw_chg_o pulse.
REQ-022 Channels SHALL be fully independent; a button event and a switch event at the same edge SHALL assert both pulses in that cycle.
REQ-023 Consecutive accepted changes SHALL be at least D cycles apart per channel; pulses SHALL therefore never merge for D >= 2.

Reset
REQ-024 While rst_i is high at an edge, all synchronizer flops, counters and stable registers SHALL be set to 0.
REQ-025 While rst_i is high at an edge, btn_o, sw_o, irq_btn_o and sw_chg_o SHALL be 0 in the following cycle.
REQ-026 Reset asserted mid-count SHALL discard the count; no output change SHALL result from pre-reset activity.
REQ-027 After reset release with an input held at 1, that output SHALL rise per REQ-017, counting the first edge with rst_i low as edge 0, and SHALL generate the corresponding pulse.

Verification (D=4, NUM_SW=16)
REQ-028 Reset check: rst_i=1 for 3 cycles with btn_i=1 and sw_i=16'hFFFF -> all outputs 0 during reset. After release -> btn_o=1 and sw_o=16'hFFFF after edge 5, plus one irq_btn_o pulse and one sw_chg_o pulse in that same cycle.
REQ-029 Bounce check: btn_i toggles 1,0,1,0... each cycle for 10 cycles, then held at 1 -> no irq_btn_o during toggling. Exactly one irq_btn_o pulse follows, 5 edges after the final hold begins.
REQ-030 Glitch check: btn_i=1 for 3 cycles, then 0 -> btn_o and irq_btn_o stay 0 throughout.
REQ-031 Switch check: sw_i goes 16'h0000 -> 16'hA5A5 at one edge -> sw_o=16'hA5A5 after edge 5 with a single sw_chg_o pulse. sw_i then returns to 16'h0000 -> sw_o=0 after 5 edges plus a second single pulse.
REQ-032 Reset mid-count check: btn_i goes to 1, rst_i pulses for 1 cycle when counter==2 -> btn_o stays 0 until 5 edges after release, then one irq_btn_o pulse.
REQ-033 Falling-edge check: btn_o=1 steady, then btn_i goes to 0 -> btn_o=0 after edge 5 and irq_btn_o stays 0.
